instruction_encoder_rv32i: RTL
==============================

Name: instruction_encoder_RV32I

Overview:
- Producer side of the instruction decode path: accepts one instruction description per handshake (one-hot class plus fields), packs it into a 32-bit RV32I/vector-extension word and writes it sequentially into instruction memory.
- Used by the program loader and self-test harness to fill instruction memory before the core is released from reset.
- Class bit order and opcodes match the core decoder, so encode-then-decode is an identity on class.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, words available (≤ 2**ADDR_W).
- BASE_ADDR, 0, first word address after start.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: restart program at BASE_ADDR; clears count and err.
- in_valid  in  1  instruction description valid.
- in_ready  out  1  encoder can accept.
- in_class  in  16  one-hot, bit0..15 = r, i_arith, i_load, store, branch, jump, i_jump, u, u_pc, i_transfer, vector_r, scalar_to_vector, vector_to_scalar, store_vector, load_vector, vector_absolute.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3;  in_funct7  in  7.
- in_imm  in  32  immediate, byte-offset semantics for branch/jump.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded word.
- word_count  out  ADDR_W+1  words written since start.
- full  out  1  word_count == DEPTH.
- err  out  1  sticky: non-one-hot class seen.

Behaviour:
- Reset: state IDLE; in_ready=0 during rst cycle then 1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; word_count=0; full=0; err=0.
- FSM: IDLE (in_ready=!full) -> on in_valid&&in_ready capture all inputs -> ENC (compute word, check class) -> WR (mem_we=1 one cycle, mem_addr/mem_wdata stable) -> IDLE. Accept-to-strobe latency 2 cycles; throughput one word per 3 cycles.
- Opcodes: 51,19,3,35,99,111,103,55,23,115,120,121,122,123,124,125 in class order.
- Formats: R-type (r, vector_r, scalar_to_vector, vector_to_scalar, vector_absolute) = funct7|rs2|rs1|f3|rd|op. I-type (i_arith, i_load, i_jump, i_transfer, load_vector) = imm[11:0]|rs1|f3|rd|op. S-type (store, store_vector) = imm[11:5]|rs2|rs1|f3|imm[4:0]|op. B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op. J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. U (u, u_pc) = imm[31:12]|rd|op.
- Class zero or multi-hot in ENC: set err, skip WR, no address/count change, return to IDLE.
- After WR: mem_addr increments; wraps to 0 when it reaches 2**ADDR_W-1. word_count increments, saturating at DEPTH.
- full: in_ready=0; in_valid ignored; no write.
- start in any state: aborts any in-flight word (no strobe); mem_addr=BASE_ADDR, word_count=0, err=0; state IDLE next cycle. start wins over a simultaneous handshake, and that word is dropped.
- rst overrides start.

Optional Feature:
- IMM_RANGE_CHECK_EN.
- Defined: ENC also flags err and skips the write if in_imm does not fit the format's signed range (I/S ±2048; B even and ±4096; J even and ±1 MiB; U low 12 bits zero).
- Undefined: out-of-range immediates are silently truncated per format.

Decomposition:
- Package rv32i_encode_pkg: class-index enum (bit order above), opcode localparams, format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U}, FSM state enum.
- Sub-module instr_pack_RV32I: purely combinational packing of fields into a word by format, used by the ENC state.

Test Plan:
- add x3,x1,x2 (class bit0, f3=0, f7=0) -> mem_wdata=0x002081B3 at addr 0, mem_we two cycles after accept.
- addi x1,x0,5 then sw x2,8(x1) -> 0x00500093 at addr 0, 0x0020A423 at addr 1, word_count=2.
- beq x1,x2,+8 -> 0x00208463; jal x1,+16 -> 0x010000EF; lui x5,0x12345000 -> 0x123452B7.
- in_class=0x0003 -> err=1, no mem_we, word_count unchanged; start -> err=0, mem_addr=0.
- DEPTH=4: four writes -> full=1, in_ready=0; fifth in_valid held -> no strobe.
- start asserted in ENC -> no mem_we, word_count=0; with IMM_RANGE_CHECK_EN, addi imm=4096 -> err=1, no write.

Source files
------------

// File: rtl/rv32i_encode_pkg.sv
// Shared definitions for the RV32I / vector-extension instruction encoder.
// Contents:
//   cls_idx_e  - bit position of each instruction class in the one-hot class vector
//   OP_*       - 7-bit major opcodes, in class order
//   fmt_e      - instruction word formats
//   state_e    - encoder FSM states
//   cls_opcode - maps a class index to its opcode
//   cls_fmt    - maps a class index to its format
// The class bit order and the opcodes match the core decoder, so a word this
// encoder writes decodes back to the class it was built from.
package rv32i_encode_pkg;

  typedef enum logic [3:0] {
    CLS_R          = 4'd0,
    CLS_I_ARITH    = 4'd1,
    CLS_I_LOAD     = 4'd2,
    CLS_STORE      = 4'd3,
    CLS_BRANCH     = 4'd4,
    CLS_JUMP       = 4'd5,
    CLS_I_JUMP     = 4'd6,
    CLS_U          = 4'd7,
    CLS_U_PC       = 4'd8,
    CLS_I_TRANSFER = 4'd9,
    CLS_VECTOR_R   = 4'd10,
    CLS_S2V        = 4'd11,
    CLS_V2S        = 4'd12,
    CLS_STORE_VEC  = 4'd13,
    CLS_LOAD_VEC   = 4'd14,
    CLS_VEC_ABS    = 4'd15
  } cls_idx_e;

  localparam logic [6:0] OP_R          = 7'd51;
  localparam logic [6:0] OP_I_ARITH    = 7'd19;
  localparam logic [6:0] OP_I_LOAD     = 7'd3;
  localparam logic [6:0] OP_STORE      = 7'd35;
  localparam logic [6:0] OP_BRANCH     = 7'd99;
  localparam logic [6:0] OP_JUMP       = 7'd111;
  localparam logic [6:0] OP_I_JUMP     = 7'd103;
  localparam logic [6:0] OP_U          = 7'd55;
  localparam logic [6:0] OP_U_PC       = 7'd23;
  localparam logic [6:0] OP_I_TRANSFER = 7'd115;
  localparam logic [6:0] OP_VECTOR_R   = 7'd120;
  localparam logic [6:0] OP_S2V        = 7'd121;
  localparam logic [6:0] OP_V2S        = 7'd122;
  localparam logic [6:0] OP_STORE_VEC  = 7'd123;
  localparam logic [6:0] OP_LOAD_VEC   = 7'd124;
  localparam logic [6:0] OP_VEC_ABS    = 7'd125;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4,
    FMT_U = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2
  } state_e;

  function automatic logic [6:0] cls_opcode(input cls_idx_e idx);
    case (idx)
      CLS_R:          return OP_R;
      CLS_I_ARITH:    return OP_I_ARITH;
      CLS_I_LOAD:     return OP_I_LOAD;
      CLS_STORE:      return OP_STORE;
      CLS_BRANCH:     return OP_BRANCH;
      CLS_JUMP:       return OP_JUMP;
      CLS_I_JUMP:     return OP_I_JUMP;
      CLS_U:          return OP_U;
      CLS_U_PC:       return OP_U_PC;
      CLS_I_TRANSFER: return OP_I_TRANSFER;
      CLS_VECTOR_R:   return OP_VECTOR_R;
      CLS_S2V:        return OP_S2V;
      CLS_V2S:        return OP_V2S;
      CLS_STORE_VEC:  return OP_STORE_VEC;
      CLS_LOAD_VEC:   return OP_LOAD_VEC;
      default:        return OP_VEC_ABS;
    endcase
  endfunction

  function automatic fmt_e cls_fmt(input cls_idx_e idx);
    case (idx)
      CLS_I_ARITH, CLS_I_LOAD, CLS_I_JUMP, CLS_I_TRANSFER, CLS_LOAD_VEC: return FMT_I;
      CLS_STORE, CLS_STORE_VEC:                                         return FMT_S;
      CLS_BRANCH:                                                       return FMT_B;
      CLS_JUMP:                                                         return FMT_J;
      CLS_U, CLS_U_PC:                                                  return FMT_U;
      default:                                                          return FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack_RV32I.sv
// Purely combinational packing of instruction fields into a 32-bit word.
// Ports:
//   fmt_i    - word format (R/I/S/B/J/U)
//   opcode_i - 7-bit major opcode
//   rd_i, rs1_i, rs2_i - register indices
//   funct3_i, funct7_i - function fields
//   imm_i    - immediate; byte-offset semantics for B and J
//   word_o   - packed instruction word
// Immediate bits that a format cannot carry are dropped here.
module instr_pack_RV32I
  import rv32i_encode_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder_rv32i.sv
// Instruction encoder: accepts one instruction description per handshake,
// packs it into an RV32I / vector-extension word and writes it to the next
// sequential instruction-memory word address.
// Optional build macro: IMM_RANGE_CHECK_EN - when defined, immediates that do
// not fit the format's signed range (or violate alignment) set err and the
// word is not written; otherwise they are silently truncated.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - restart at BASE_ADDR, clear word_count and err, abort in-flight word
//   in_valid/in_ready - description handshake
//   in_class       - one-hot instruction class
//   in_rd/in_rs1/in_rs2/in_funct3/in_funct7/in_imm - instruction fields
//   mem_we/mem_addr/mem_wdata - single-cycle memory write port
//   word_count     - words written since start (saturates at DEPTH)
//   full           - word_count == DEPTH
//   err            - sticky bad-class (or bad-immediate) flag
module instruction_encoder_rv32i
  import rv32i_encode_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);

  state_e state_q, state_d;

  logic [15:0]        cls_q;
  logic [4:0]         rd_q, rs1_q, rs2_q;
  logic [2:0]         f3_q;
  logic [6:0]         f7_q;
  logic signed [31:0] imm_q;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;

  logic               accept;
  cls_idx_e           cls_idx;
  fmt_e               enc_fmt;
  logic [6:0]         enc_op;
  logic [31:0]        enc_word;
  logic               cls_ok, imm_ok, enc_ok;

`ifdef IMM_RANGE_CHECK_EN
  function automatic logic imm_fits(input fmt_e f, input logic signed [31:0] v);
    case (f)
      FMT_I, FMT_S: return (v >= -2048) && (v <= 2047);
      FMT_B:        return !v[0] && (v >= -4096) && (v <= 4095);
      FMT_J:        return !v[0] && (v >= -1048576) && (v <= 1048575);
      FMT_U:        return (v[11:0] == 12'd0);
      default:      return 1'b1;
    endcase
  endfunction
`endif

  assign full     = (count_q == CNT_MAX);
  // start wins over a simultaneous handshake: the offered word is dropped.
  assign accept   = in_valid && in_ready && !start;

  // ---- stage p0: capture description on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      cls_q <= in_class;
      rd_q  <= in_rd;
      rs1_q <= in_rs1;
      rs2_q <= in_rs2;
      f3_q  <= in_funct3;
      f7_q  <= in_funct7;
      imm_q <= in_imm;
    end
  end

  // ---- stage p1: class decode and word packing (ENC) ----
  always_comb begin
    cls_idx = CLS_R;
    for (int k = 0; k < 16; k++) begin
      if (cls_q[k]) cls_idx = cls_idx_e'(k);
    end
  end

  assign cls_ok  = $onehot(cls_q);
  assign enc_fmt = cls_fmt(cls_idx);
  assign enc_op  = cls_opcode(cls_idx);
`ifdef IMM_RANGE_CHECK_EN
  assign imm_ok  = imm_fits(enc_fmt, imm_q);
`else
  assign imm_ok  = 1'b1;
`endif
  assign enc_ok  = cls_ok && imm_ok;

  instr_pack_RV32I u_pack (
    .fmt_i    (enc_fmt),
    .opcode_i (enc_op),
    .rd_i     (rd_q),
    .rs1_i    (rs1_q),
    .rs2_i    (rs2_q),
    .funct3_i (f3_q),
    .funct7_i (f7_q),
    .imm_i    (imm_q),
    .word_o   (enc_word)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ENC;
      S_ENC:   state_d = (enc_ok && !start) ? S_WR : S_IDLE;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_IDLE;
  end

  // FSM: outputs (rst and start both suppress the strobe in the same cycle)
  always_comb begin
    in_ready = (state_q == S_IDLE) && !full && !rst;
    mem_we   = (state_q == S_WR) && !start && !rst;
  end

  // ---- stage p2: write bookkeeping (WR) ----
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (start) begin
      addr_d  = ADDR_BASE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_ENC: begin
          if (enc_ok) wdata_d = enc_word;
          else        err_d   = 1'b1;
        end
        S_WR: begin
          addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= ADDR_BASE;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;

endmodule
